// File: rtl/mem_access_ctrl_pkg.sv
// Purpose : shared widths and FSM state encoding for the memory access controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a. Contents: ADDR_W, DATA_W, CNT_W, state_e.
package mem_ctrl_pkg;

    localparam int ADDR_W = 3;  // 8 words, matches the 3-to-8 word-select decoder
    localparam int DATA_W = 8;  // word width
    localparam int CNT_W  = 4;  // access down-counter, covers ACCESS_CYCLES 1..15

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Purpose : bundles the request, decoder/cell-array and response signals of the controller.
// Latency : n/a (wiring only).
// Backpressure: request uses valid/ready, response uses valid/ready.
// Modports: master = requester, cell-array and response consumer side; slave = controller.
interface mem_access_ctrl_if;
    import mem_ctrl_pkg::*;

    // request channel
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_write;
    logic [ADDR_W-1:0] i_req_addr;
    logic [DATA_W-1:0] i_req_wdata;
    // decoder and cell array
    logic [ADDR_W-1:0] o_dec_address;
    logic              o_dec_valid;
    logic              o_write_en;
    logic              o_read_en;
    logic [DATA_W-1:0] o_wdata;
    logic [DATA_W-1:0] i_rdata;
    // response channel
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_data;

    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_rdata, i_rsp_ready,
        input  o_req_ready, o_dec_address, o_dec_valid, o_write_en, o_read_en, o_wdata,
               o_rsp_valid, o_rsp_data
    );

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_rdata, i_rsp_ready,
        output o_req_ready, o_dec_address, o_dec_valid, o_write_en, o_read_en, o_wdata,
               o_rsp_valid, o_rsp_data
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// Purpose : sequences one read/write at a time into the word decoder and cell array.
// Latency : request accepted at cycle 0 -> SETUP cycle 1, strobes cycles 2..1+N, done/response at 2+N.
// Backpressure: o_req_ready only in IDLE; a read response is held in RESP until i_rsp_ready.
// Ports: i_clk, i_reset (sync, active-high), bus (mem_access_ctrl_if.slave: request,
//        decoder/array and response signals).
// Optional: MEM_ACCESS_CTRL_RAW_FWD_EN forwards the last completed write to a matching read,
//           going IDLE -> RESP with no decoder or strobe activity.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2   // strobe length, legal 1..15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mem_access_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_q;

    logic              accept;
    logic              last_access;
    logic              fwd_hit;

    logic              req_ready;
    logic              dec_valid;
    logic              write_en;
    logic              read_en;
    logic [DATA_W-1:0] wdata_out;
    logic              rsp_valid;

`ifdef MEM_ACCESS_CTRL_RAW_FWD_EN
    logic              lw_vld_q;
    logic [ADDR_W-1:0] lw_addr_q;
    logic [DATA_W-1:0] lw_data_q;

    assign fwd_hit = !bus.i_req_write && lw_vld_q && (lw_addr_q == bus.i_req_addr);
`else
    assign fwd_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state and Moore outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        last_access = 1'b0;
        req_ready   = 1'b0;
        dec_valid   = 1'b0;
        write_en    = 1'b0;
        read_en     = 1'b0;
        wdata_out   = '0;
        rsp_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.i_req_valid) begin
                    accept  = 1'b1;
                    state_d = fwd_hit ? RESP : SETUP;
                end
            end
            SETUP: begin
                dec_valid = 1'b1;
                cnt_d     = CNT_W'(ACCESS_CYCLES - 1);
                state_d   = ACCESS;
            end
            ACCESS: begin
                dec_valid = 1'b1;
                write_en  = write_q;
                read_en   = !write_q;
                wdata_out = write_q ? wdata_q : '0;
                if (cnt_q == '0) begin
                    last_access = 1'b1;
                    state_d     = write_q ? IDLE : RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // request latch, read capture and (optionally) the last-write register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
`ifdef MEM_ACCESS_CTRL_RAW_FWD_EN
            lw_vld_q  <= 1'b0;
            lw_addr_q <= '0;
            lw_data_q <= '0;
`endif
        end else begin
            if (accept) begin
                write_q <= bus.i_req_write;
                wdata_q <= bus.i_req_wdata;
                // a forwarded read never touches the decoder, so its address is not latched
                if (!fwd_hit) begin
                    addr_q <= bus.i_req_addr;
                end
`ifdef MEM_ACCESS_CTRL_RAW_FWD_EN
                if (fwd_hit) begin
                    rsp_q <= lw_data_q;
                end
`endif
            end
            if (last_access && !write_q) begin
                rsp_q <= bus.i_rdata;
            end
`ifdef MEM_ACCESS_CTRL_RAW_FWD_EN
            if (last_access && write_q) begin
                lw_vld_q  <= 1'b1;
                lw_addr_q <= addr_q;
                lw_data_q <= wdata_q;
            end
`endif
        end
    end

    assign bus.o_req_ready   = req_ready;
    assign bus.o_dec_address = addr_q;    // held while o_dec_valid is low
    assign bus.o_dec_valid   = dec_valid;
    assign bus.o_write_en    = write_en;
    assign bus.o_read_en     = read_en;
    assign bus.o_wdata       = wdata_out;
    assign bus.o_rsp_valid   = rsp_valid;
    assign bus.o_rsp_data    = rsp_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose : directed, table-driven check of mem_access_ctrl with a simple 8x8 cell-array model.
// Latency : each access checked cycle by cycle against the 2+N timing (N = ACCESS_CYCLES).
// Backpressure: response stall of 5 cycles exercised on a read of addr 7.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int N = 2;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp;   // expected read data (unused for writes)
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [DATA_W-1:0] mem [8];

    // reference for the optional forwarding path: last completed write
    logic              lw_vld;
    logic [ADDR_W-1:0] lw_addr;

    vec_t vecs [22];

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.ACCESS_CYCLES(N)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cell-array model: combinational read, write on the strobe
    assign bus.i_rdata = mem[bus.o_dec_address];
    always @(posedge clk) begin
        if (bus.o_write_en) mem[bus.o_dec_address] <= bus.o_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic fwd;
        fwd = 1'b0;
`ifdef MEM_ACCESS_CTRL_RAW_FWD_EN
        fwd = !v.wr && lw_vld && (lw_addr == v.addr);
`endif
        chk("idle_ready", int'(bus.o_req_ready), 1);
        bus.i_req_valid = 1'b1;
        bus.i_req_write = v.wr;
        bus.i_req_addr  = v.addr;
        bus.i_req_wdata = v.wdata;
        tick();                         // cycle 0 edge: accepted
        bus.i_req_valid = 1'b0;
        bus.i_req_wdata = '0;
        if (fwd) begin
            chk("fwd_rsp_valid", int'(bus.o_rsp_valid), 1);
            chk("fwd_rsp_data",  int'(bus.o_rsp_data), int'(v.exp));
            chk("fwd_no_read_en", int'(bus.o_read_en), 0);
            chk("fwd_no_dec_valid", int'(bus.o_dec_valid), 0);
        end else begin
            // cycle 1: SETUP
            chk("setup_dec_valid", int'(bus.o_dec_valid), 1);
            chk("setup_dec_addr",  int'(bus.o_dec_address), int'(v.addr));
            chk("setup_no_strobe", int'(bus.o_write_en | bus.o_read_en), 0);
            chk("setup_not_ready", int'(bus.o_req_ready), 0);
            // cycles 2..1+N: ACCESS
            for (int k = 0; k < N; k++) begin
                tick();
                chk("acc_write_en",  int'(bus.o_write_en), int'(v.wr));
                chk("acc_read_en",   int'(bus.o_read_en), int'(!v.wr));
                chk("acc_dec_valid", int'(bus.o_dec_valid), 1);
                chk("acc_dec_addr",  int'(bus.o_dec_address), int'(v.addr));
                chk("acc_wdata",     int'(bus.o_wdata), v.wr ? int'(v.wdata) : 0);
                chk("acc_not_ready", int'(bus.o_req_ready), 0);
            end
            tick();                     // cycle 2+N
            chk("end_dec_valid", int'(bus.o_dec_valid), 0);
            chk("end_no_strobe", int'(bus.o_write_en | bus.o_read_en), 0);
            if (v.wr) begin
                chk("wr_ready_again", int'(bus.o_req_ready), 1);
                chk("wr_no_rsp", int'(bus.o_rsp_valid), 0);
                lw_vld  = 1'b1;
                lw_addr = v.addr;
            end else begin
                chk("rd_rsp_valid", int'(bus.o_rsp_valid), 1);
                chk("rd_rsp_data",  int'(bus.o_rsp_data), int'(v.exp));
                chk("rd_not_ready", int'(bus.o_req_ready), 0);
            end
        end
        if (!v.wr) begin
            bus.i_rsp_ready = 1'b1;
            tick();                     // handshake
            bus.i_rsp_ready = 1'b0;
            chk("rsp_done_ready", int'(bus.o_req_ready), 1);
            chk("rsp_done_valid", int'(bus.o_rsp_valid), 0);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] held;
        n_cmp = 0;
        n_err = 0;
        lw_vld  = 1'b0;
        lw_addr = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // stimulus table
        vecs[0] = '{wr: 1'b1, addr: 3'd3, wdata: 8'hA5, exp: 8'h00};
        vecs[1] = '{wr: 1'b0, addr: 3'd3, wdata: 8'h00, exp: 8'hA5};
        for (int a = 0; a < 8; a++) begin
            vecs[2 + 2*a] = '{wr: 1'b1, addr: 3'(a), wdata: 8'(a) ^ 8'h3C, exp: 8'h00};
            vecs[3 + 2*a] = '{wr: 1'b0, addr: 3'(a), wdata: 8'h00, exp: 8'(a) ^ 8'h3C};
        end
        vecs[18] = '{wr: 1'b1, addr: 3'd0, wdata: 8'h3C, exp: 8'h00};
        vecs[19] = '{wr: 1'b1, addr: 3'd2, wdata: 8'h5A, exp: 8'h00};
        vecs[20] = '{wr: 1'b0, addr: 3'd2, wdata: 8'h00, exp: 8'h5A};
        vecs[21] = '{wr: 1'b0, addr: 3'd4, wdata: 8'h00, exp: 8'h38};

        bus.i_req_valid = 1'b0;
        bus.i_req_write = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_wdata = '0;
        bus.i_rsp_ready = 1'b0;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready",     int'(bus.o_req_ready), 1);
        chk("rst_dec_valid", int'(bus.o_dec_valid), 0);
        chk("rst_dec_addr",  int'(bus.o_dec_address), 0);
        chk("rst_strobes",   int'(bus.o_write_en | bus.o_read_en), 0);
        chk("rst_wdata",     int'(bus.o_wdata), 0);
        chk("rst_rsp",       int'(bus.o_rsp_valid), 0);
        chk("rst_rsp_data",  int'(bus.o_rsp_data), 0);

        // reset in the middle of a write's ACCESS phase (addr 5)
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b1;
        bus.i_req_addr  = 3'd5;
        bus.i_req_wdata = 8'h11;
        tick();
        bus.i_req_valid = 1'b0;
        tick();
        chk("midrst_in_access", int'(bus.o_write_en), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lw_vld = 1'b0;
        chk("midrst_ready",     int'(bus.o_req_ready), 1);
        chk("midrst_write_en",  int'(bus.o_write_en), 0);
        chk("midrst_dec_valid", int'(bus.o_dec_valid), 0);

        // table-driven accesses
        for (int i = 0; i < 22; i++) run_vec(vecs[i]);

        // read addr 7 with the response stalled for 5 cycles
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b0;
        bus.i_req_addr  = 3'd7;
        tick();
        bus.i_req_valid = 1'b0;
        for (int k = 0; k <= N; k++) tick();
        chk("stall_rsp_valid", int'(bus.o_rsp_valid), 1);
        chk("stall_rsp_data",  int'(bus.o_rsp_data), 8'h3B);
        held = bus.o_rsp_data;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_hold_valid", int'(bus.o_rsp_valid), 1);
            chk("stall_hold_data",  int'(bus.o_rsp_data), int'(held));
            chk("stall_not_ready",  int'(bus.o_req_ready), 0);
        end
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        chk("stall_ready_after", int'(bus.o_req_ready), 1);
        chk("stall_valid_after", int'(bus.o_rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
